// File: rtl/bht_pkg.sv
// -----------------------------------------------------------------------------
// bht_pkg
// Shared helpers for the gshare branch history table:
//   - weak-taken / weak-not-taken counter encodings for an arbitrary width
//   - saturating increment / decrement
//   - table index hash (PC word bits, optionally XOR-ed with global history)
// Functions work on 32-bit containers; callers size-cast the result to the
// width they need, so any CTR_BITS / INDEX_BITS up to 32 is supported.
// -----------------------------------------------------------------------------
package bht_pkg;

    // Mask with the low w bits set.
    function automatic logic [31:0] low_mask(input int unsigned w);
        return (w >= 32'd32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Weakly taken: MSB set, remaining bits clear.
    function automatic logic [31:0] ctr_weak_taken(input int unsigned w);
        return 32'd1 << (w - 32'd1);
    endfunction

    // Weakly not-taken: MSB clear, remaining bits set.
    function automatic logic [31:0] ctr_weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    // Increment, saturating at all-ones for a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] c, input int unsigned w);
        return (c == low_mask(w)) ? c : (c + 32'd1);
    endfunction

    // Decrement, saturating at zero.
    function automatic logic [31:0] sat_dec(input logic [31:0] c);
        return (c == 32'd0) ? c : (c - 32'd1);
    endfunction

    // Table index: PC word-address bits, XOR-ed with history when gshare is on.
    // The byte-offset bits [1:0] are always dropped.
    function automatic logic [31:0] bht_hash(input logic [31:0] pc,
                                             input logic [31:0] hist,
                                             input int unsigned idx_bits,
                                             input bit          use_gshare);
        logic [31:0] base;
        base = (pc >> 2) & low_mask(idx_bits);
        return use_gshare ? (base ^ (hist & low_mask(idx_bits))) : base;
    endfunction

endpackage

// File: rtl/bht_sat_ctr_array.sv
// -----------------------------------------------------------------------------
// bht_sat_ctr_array
// Valid bits plus saturating counters, 2**INDEX_BITS entries.
//   clk, rst        : clock, asynchronous active-high clear of all entries
//   rd_idx          : combinational read index
//   rd_valid/rd_ctr : entry state at rd_idx (pre-write, no bypass)
//   wr_en/wr_idx    : train the entry at wr_idx on the rising edge
//   wr_taken        : resolved outcome; a cold entry is seeded weak-taken or
//                     weak-not-taken, a warm entry steps up or down saturating
// -----------------------------------------------------------------------------
module bht_sat_ctr_array
    import bht_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned CTR_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [CTR_BITS-1:0]   rd_ctr,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);

    localparam int unsigned ENTRIES = 32'd1 << INDEX_BITS;

    logic [ENTRIES-1:0]  valid_r;
    logic [CTR_BITS-1:0] ctr_r [ENTRIES];
    logic [CTR_BITS-1:0] next_ctr_s;

    assign rd_valid = valid_r[rd_idx];
    assign rd_ctr   = ctr_r[rd_idx];

    // Next counter value for the entry being trained.
    always_comb begin
        next_ctr_s = ctr_r[wr_idx];
        if (!valid_r[wr_idx]) begin
            next_ctr_s = wr_taken ? CTR_BITS'(ctr_weak_taken(CTR_BITS))
                                  : CTR_BITS'(ctr_weak_not_taken(CTR_BITS));
        end else if (wr_taken) begin
            next_ctr_s = CTR_BITS'(sat_inc(32'(ctr_r[wr_idx]), CTR_BITS));
        end else begin
            next_ctr_s = CTR_BITS'(sat_dec(32'(ctr_r[wr_idx])));
        end
    end

    // Entry storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_r[i] <= '0;
            end
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
            ctr_r[wr_idx]   <= next_ctr_s;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/bht_gshare.sv
// -----------------------------------------------------------------------------
// bht_gshare
// Branch predictor with optional gshare indexing, speculative global history
// and resolve-time training.
//   clk, rst       : clock, asynchronous active-high reset
//   lu_*           : decode-stage lookup; lu_taken/lu_ctr/lu_hit/lu_ghr are
//                    combinational from the current table and history
//   up_*           : execute-stage resolve; trains the counter indexed with the
//                    history snapshot that travelled with the branch, and
//                    repairs the history on a mispredict
//   ghr            : current speculative global history
//   br_cnt/mis_cnt : resolved branch and mispredict counts (wrap at 2**32)
// -----------------------------------------------------------------------------
module bht_gshare
    import bht_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned GHR_BITS   = 8,
    parameter bit          USE_GSHARE = 1'b1,
    parameter bit          COLD_BTFN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lu_valid,
    input  logic [31:0]         lu_pc,
    input  logic                lu_backward,
    input  logic                lu_jump,
    output logic                lu_taken,
    output logic [CTR_BITS-1:0] lu_ctr,
    output logic                lu_hit,
    output logic [GHR_BITS-1:0] lu_ghr,
    input  logic                up_valid,
    input  logic [31:0]         up_pc,
    input  logic [GHR_BITS-1:0] up_ghr,
    input  logic                up_taken,
    input  logic                up_mispredict,
    output logic [GHR_BITS-1:0] ghr,
    output logic [31:0]         br_cnt,
    output logic [31:0]         mis_cnt
);

    logic [GHR_BITS-1:0]   ghr_r;
    logic [GHR_BITS-1:0]   ghr_next_s;
    logic [31:0]           br_cnt_r;
    logic [31:0]           mis_cnt_r;
    logic [INDEX_BITS-1:0] lu_idx_s;
    logic [INDEX_BITS-1:0] up_idx_s;
    logic                  rd_valid_s;
    logic [CTR_BITS-1:0]   rd_ctr_s;
    logic                  lu_taken_s;

    assign lu_idx_s = INDEX_BITS'(bht_hash(lu_pc, 32'(ghr_r),  INDEX_BITS, USE_GSHARE));
    assign up_idx_s = INDEX_BITS'(bht_hash(up_pc, 32'(up_ghr), INDEX_BITS, USE_GSHARE));

    bht_sat_ctr_array #(
        .INDEX_BITS (INDEX_BITS),
        .CTR_BITS   (CTR_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lu_idx_s),
        .rd_valid (rd_valid_s),
        .rd_ctr   (rd_ctr_s),
        .wr_en    (up_valid),
        .wr_idx   (up_idx_s),
        .wr_taken (up_taken)
    );

    // Prediction: jumps always taken, warm entries use the counter MSB,
    // cold entries fall back to the static rule.
    always_comb begin
        lu_taken_s = 1'b0;
        if (lu_jump) begin
            lu_taken_s = 1'b1;
        end else if (rd_valid_s) begin
            lu_taken_s = rd_ctr_s[CTR_BITS-1];
        end else begin
            lu_taken_s = COLD_BTFN ? lu_backward : 1'b0;
        end
    end

    // History next state: mispredict repair beats the speculative shift.
    // The size cast drops the oldest bit, which also covers GHR_BITS = 1.
    always_comb begin
        ghr_next_s = ghr_r;
        if (up_valid && up_mispredict) begin
            ghr_next_s = GHR_BITS'({up_ghr, up_taken});
        end else if (lu_valid && !lu_jump) begin
            ghr_next_s = GHR_BITS'({ghr_r, lu_taken_s});
        end else begin
            ghr_next_s = ghr_r;
        end
    end

    // History and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_r     <= '0;
            br_cnt_r  <= 32'd0;
            mis_cnt_r <= 32'd0;
        end else begin
            ghr_r <= ghr_next_s;
            if (up_valid) begin
                br_cnt_r  <= br_cnt_r + 32'd1;
                mis_cnt_r <= mis_cnt_r + (up_mispredict ? 32'd1 : 32'd0);
            end else begin
                br_cnt_r  <= br_cnt_r;
                mis_cnt_r <= mis_cnt_r;
            end
        end
    end

    assign lu_taken = lu_taken_s;
    assign lu_ctr   = rd_ctr_s;
    assign lu_hit   = rd_valid_s;
    assign lu_ghr   = ghr_r;
    assign ghr      = ghr_r;
    assign br_cnt   = br_cnt_r;
    assign mis_cnt  = mis_cnt_r;

endmodule

// File: tb/tb_bht_gshare.sv
module tb_bht_gshare;

    localparam int IB   = 8;
    localparam int CB   = 2;
    localparam int GB   = 8;
    localparam int NENT = 1 << IB;
    localparam int HALF = 1 << (CB - 1);
    localparam int MAXC = (1 << CB) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lu_valid = 1'b0, lu_backward = 1'b0, lu_jump = 1'b0;
    logic [31:0] lu_pc = 32'd0;
    logic        lu_taken, lu_hit;
    logic [CB-1:0] lu_ctr;
    logic [GB-1:0] lu_ghr, ghr;
    logic        up_valid = 1'b0, up_taken = 1'b0, up_mispredict = 1'b0;
    logic [31:0] up_pc = 32'd0;
    logic [GB-1:0] up_ghr = '0;
    logic [31:0] br_cnt, mis_cnt;

    bht_gshare #(
        .INDEX_BITS(IB), .CTR_BITS(CB), .GHR_BITS(GB),
        .USE_GSHARE(1'b1), .COLD_BTFN(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .lu_valid(lu_valid), .lu_pc(lu_pc), .lu_backward(lu_backward), .lu_jump(lu_jump),
        .lu_taken(lu_taken), .lu_ctr(lu_ctr), .lu_hit(lu_hit), .lu_ghr(lu_ghr),
        .up_valid(up_valid), .up_pc(up_pc), .up_ghr(up_ghr), .up_taken(up_taken),
        .up_mispredict(up_mispredict),
        .ghr(ghr), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: plain integer counters per table slot.
    int          m_ctr   [NENT];
    bit          m_valid [NENT];
    int unsigned m_ghr;
    int unsigned m_br, m_mis;

    // Lookup results observed during the most recent cycle() call.
    logic        obs_taken, obs_hit;
    logic [31:0] obs_ctr;

    typedef struct {
        logic        lv;
        logic [31:0] pc;
        logic        bw, jp, uv;
        logic [31:0] upc;
        logic [7:0]  ug;
        logic        ut, um;
        logic        e_taken, e_hit;
        logic [1:0]  e_ctr;
        logic [7:0]  e_ghr;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_ctr[i]   = 0;
            m_valid[i] = 1'b0;
        end
        m_ghr = 0;
        m_br  = 0;
        m_mis = 0;
    endtask

    function automatic int unsigned m_idx(input logic [31:0] pc, input int unsigned h);
        return ((pc / 4) ^ h) % NENT;
    endfunction

    // One clock of stimulus: check the lookup before the edge, then the
    // registered state after it, both against the reference model.
    task automatic cycle(input logic lv, input logic [31:0] pc, input logic bw, input logic jp,
                         input logic uv, input logic [31:0] upc, input logic [7:0] ug,
                         input logic ut, input logic um);
        int unsigned li, ui;
        logic        e_taken;
        lu_valid = lv; lu_pc = pc; lu_backward = bw; lu_jump = jp;
        up_valid = uv; up_pc = upc; up_ghr = ug; up_taken = ut; up_mispredict = um;
        #1;
        li = m_idx(pc, m_ghr);
        if (jp)                e_taken = 1'b1;
        else if (m_valid[li])  e_taken = (m_ctr[li] >= HALF);
        else                   e_taken = bw;
        chk("lu_taken", 32'(lu_taken), 32'(e_taken));
        chk("lu_hit",   32'(lu_hit),   32'(m_valid[li]));
        chk("lu_ctr",   32'(lu_ctr),   32'(m_ctr[li]));
        chk("lu_ghr",   32'(lu_ghr),   m_ghr);
        obs_taken = lu_taken; obs_hit = lu_hit; obs_ctr = 32'(lu_ctr);
        @(posedge clk);
        if (uv) begin
            ui = m_idx(upc, ug);
            if (!m_valid[ui]) begin
                m_valid[ui] = 1'b1;
                m_ctr[ui]   = ut ? HALF : HALF - 1;
            end else if (ut) begin
                m_ctr[ui] = (m_ctr[ui] < MAXC) ? m_ctr[ui] + 1 : MAXC;
            end else begin
                m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
            end
            m_br++;
            if (um) m_mis++;
            if (um) m_ghr = ((ug * 2) + ut) % (1 << GB);
            else if (lv && !jp) m_ghr = ((m_ghr * 2) + e_taken) % (1 << GB);
        end else if (lv && !jp) begin
            m_ghr = ((m_ghr * 2) + e_taken) % (1 << GB);
        end
        #1;
        chk("ghr",     32'(ghr), m_ghr);
        chk("br_cnt",  br_cnt,   m_br);
        chk("mis_cnt", mis_cnt,  m_mis);
    endtask

    initial begin
        //        lv  pc        bw jp  uv upc       ug  ut um   taken hit ctr ghr
        vt[0]  = '{1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h0};
        vt[1]  = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0};
        vt[2]  = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h40,  8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h0};
        vt[3]  = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h40,  8'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 8'h0};
        vt[4]  = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h40,  8'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 8'h0};
        vt[5]  = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h40,  8'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 8'h0};
        vt[6]  = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h40,  8'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'h0};
        vt[7]  = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h40,  8'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h0};
        vt[8]  = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b1, 32'h40,  8'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h0};
        vt[9]  = '{1'b0, 32'h40,  1'b0, 1'b0, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h0};
        vt[10] = '{1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h1};
        vt[11] = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h2};
        vt[12] = '{1'b1, 32'h208, 1'b1, 1'b0, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h5};
        vt[13] = '{1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h500, 8'h1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h2};
        vt[14] = '{1'b0, 32'h44,  1'b0, 1'b0, 1'b1, 32'h40,  8'h3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h2};
        vt[15] = '{1'b0, 32'h44,  1'b0, 1'b0, 1'b1, 32'h40,  8'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h2};
        vt[16] = '{1'b0, 32'h48,  1'b0, 1'b0, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h2};
        vt[17] = '{1'b0, 32'h44,  1'b0, 1'b0, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h2};
        vt[18] = '{1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 32'h0,   8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h2};

        model_reset();
        #3;
        chk("rst_ghr",     32'(ghr), 32'd0);
        chk("rst_br_cnt",  br_cnt,   32'd0);
        chk("rst_mis_cnt", mis_cnt,  32'd0);
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: cold lookup, training, GHR shift/repair, aliasing, jump.
        for (int i = 0; i < 19; i++) begin
            cycle(vt[i].lv, vt[i].pc, vt[i].bw, vt[i].jp, vt[i].uv, vt[i].upc,
                  vt[i].ug, vt[i].ut, vt[i].um);
            chk($sformatf("tbl%0d_taken", i), 32'(obs_taken), 32'(vt[i].e_taken));
            chk($sformatf("tbl%0d_hit", i),   32'(obs_hit),   32'(vt[i].e_hit));
            chk($sformatf("tbl%0d_ctr", i),   obs_ctr,        32'(vt[i].e_ctr));
            chk($sformatf("tbl%0d_ghr", i),   32'(ghr),       32'(vt[i].e_ghr));
        end
        chk("tbl_br_total",  br_cnt,  32'd10);
        chk("tbl_mis_total", mis_cnt, 32'd1);

        // Fresh start, then 10 resolves with 3 mispredicts.
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(i * 4), 8'h0, 1'(i % 2), 1'(i % 3 == 2));
        end
        chk("stats_br",  br_cnt,  32'd10);
        chk("stats_mis", mis_cnt, 32'd3);

        // Asynchronous reset pulse between edges clears everything at once.
        lu_valid = 1'b0; lu_jump = 1'b0; lu_pc = 32'h0; up_valid = 1'b0; up_mispredict = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_ghr",    32'(ghr),    32'd0);
        chk("arst_br",     br_cnt,      32'd0);
        chk("arst_mis",    mis_cnt,     32'd0);
        chk("arst_hit",    32'(lu_hit), 32'd0);
        chk("arst_ctr",    32'(lu_ctr), 32'd0);
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] ug;
            ug = ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom_range(0, 255));
            cycle(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_03FC, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_03FC, ug, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bht_gshare.md
Name: bht_gshare

Overview:
- Parametrised successor to the 2-bit per-PC branch history table; generalised counter width, table depth and optional gshare indexing via a speculative global history register (GHR).
- Sits between IF/ID (lookup port, combinational prediction feeding the PC-select mux) and EX (resolve port, trains counters and repairs the GHR on mispredict).
- Adds first-touch training, static fallback for cold entries, GHR checkpoint/recovery and performance counters.

Parameters:
- INDEX_BITS, 8, log2 of table depth; entries = 2**INDEX_BITS.
- CTR_BITS, 2, saturating counter width (>=1).
- GHR_BITS, 8, global history length (1..INDEX_BITS).
- USE_GSHARE, 1, 1 = index = pc bits XOR GHR; 0 = pc bits only (bimodal).
- COLD_BTFN, 1, cold-entry prediction: 1 = backward-taken/forward-not-taken, 0 = always not-taken.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- lu_valid  in  1  decode presents a conditional branch this cycle.
- lu_pc  in  32  branch PC.
- lu_backward  in  1  branch offset negative.
- lu_jump  in  1  unconditional jump (PCSrc); forces taken prediction.
- lu_taken  out  1  prediction, mux select.
- lu_ctr  out  CTR_BITS  raw counter at lookup index.
- lu_hit  out  1  entry valid.
- lu_ghr  out  GHR_BITS  GHR snapshot before this lookup; carried down pipeline.
- up_valid  in  1  EX resolves a conditional branch.
- up_pc  in  32  resolved branch PC.
- up_ghr  in  GHR_BITS  snapshot returned from lu_ghr.
- up_taken  in  1  actual outcome.
- up_mispredict  in  1  prediction was wrong.
- ghr  out  GHR_BITS  current speculative GHR.
- br_cnt  out  32  resolved branches.
- mis_cnt  out  32  mispredicts.

Behaviour:
- Reset (async): all counters = 0, all valid = 0, ghr = 0, br_cnt = mis_cnt = 0. Outputs then combinationally reflect the cleared state.
- Index:
  - lu_idx = lu_pc[INDEX_BITS+1:2] XOR zero-extended ghr; up_idx = up_pc[INDEX_BITS+1:2] XOR zero-extended up_ghr.
  - With USE_GSHARE=0, the XOR term is dropped.
- Lookup (combinational, zero latency):
  - lu_jump=1 -> lu_taken = 1.
  - Else if valid[lu_idx] -> lu_taken = ctr[lu_idx][CTR_BITS-1].
  - Else -> lu_taken = COLD_BTFN ? lu_backward : 0.
  - lu_hit = valid[lu_idx]; lu_ctr = ctr[lu_idx]; lu_ghr = ghr.
- Update (posedge, when up_valid=1):
  - If valid[up_idx]=0: set valid=1; ctr = weak-taken (MSB=1, rest 0) if up_taken, else weak-not-taken (MSB=0, rest 1).
  - Else: ctr +1 saturating at all-ones if up_taken; -1 saturating at 0 otherwise.
  - br_cnt += 1; mis_cnt += up_mispredict. Both wrap modulo 2**32.
- GHR (posedge), in priority order:
  1. up_valid and up_mispredict -> ghr = {up_ghr[GHR_BITS-2:0], up_taken}. The lookup shift that cycle is discarded.
  2. Else lu_valid and not lu_jump -> ghr = {ghr[GHR_BITS-2:0], lu_taken}.
  3. Else hold.
  - GHR_BITS=1 -> ghr = the shifted-in bit.
- Same-cycle lookup and update to the same index: lookup sees pre-update state (no bypass); the write lands at the edge.
- up_valid=0 -> no table, counter or GHR writes from the update port; up_mispredict is ignored.
- Reset asserted mid-operation clears everything immediately, regardless of clk; in-flight snapshots are meaningless afterwards.

Decomposition:
- Package bht_pkg holds:
  - CTR weak-taken/weak-not-taken constant functions parametrised by width.
  - Saturating inc/dec functions.
  - Index hash function.
- One sub-module, bht_sat_ctr_array: valid+counter storage with one combinational read port, one write port and async clear.
- Top level holds hashing, GHR and stats.

Test Plan:
- Reset, then lookup pc=0x100, lu_backward=1 (COLD_BTFN=1) -> lu_taken=1, lu_hit=0, lu_ctr=0; with lu_backward=0 -> lu_taken=0.
- USE_GSHARE=0: resolve pc=0x40 taken 4 times -> ctr sequence 2,3,3,3, lu_taken=1; then 2 not-taken -> ctr 2,1, lu_taken=0.
- GHR: lookups predicting T,N,T -> ghr=0b101. Then mispredict with up_ghr=0b1, up_taken=0, plus a same-cycle lookup -> ghr=0b10, lookup shift dropped.
- Gshare aliasing: same pc with ghr=0x00 vs 0x03 trains two distinct entries (idx 0x10 vs 0x13); each entry's counter is independent.
- Same-cycle lookup and update at one index, ctr=1, update taken -> lu_ctr shows 1 that cycle, 2 the next.
- 10 resolves with 3 mispredicts -> br_cnt=10, mis_cnt=3; async rst pulse between clock edges -> all cleared before the next edge.
